multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Main control FSM for the multicycle ARM core. Steps each instruction through fetch, decode,
//  address/execute and writeback, driving the shared ALU, memory and register-file muxes and enables.
//  RegW/MemW/PCS are raw (unconditioned) and go to conditional_logic, which gates them with CondEx.
//  Holds in memory states until the unified memory signals MemReady.
// PARAMETERS
//  STATE_W     4  state register width; 10 encodings used, all others illegal
//  MEM_WAIT_EN 1  1: FETCH/MEMRD/MEMWR wait for MemReady; 0: treat MemReady as always 1
// PORTS
//  CLK        in   1  rising-edge clock
//  nRESET     in   1  asynchronous active-low reset
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20] (I, cmd[3:0], S/L)
//  Rd         in   4  Instr[15:12]
//  MemReady   in   1  memory access completes this cycle
//  IRWrite    out  1  load instruction register
//  NextPC     out  1  unconditional PC <= PC+4 (fetch)
//  RegW       out  1  raw register write request
//  MemW       out  1  raw memory write request
//  PCS        out  1  raw PC-source request: Branch | (RegW & Rd==15)
//  AdrSrc     out  1  memory address: 0=PC, 1=ALUOut
//  ALUSrcA    out  1  0=RD1, 1=PC
//  ALUSrcB    out  2  00=RD2, 01=ExtImm, 10=constant 4
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUOp      out  1  ALU decoder uses Funct (else ADD)
//  Illegal    out  1  one-cycle pulse: Op=11 decoded
//  State      out  STATE_W  current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9.
//  Moore outputs, decoded from State; unlisted outputs are 0.
//   FETCH : AdrSrc=0 ALUSrcA=1 ALUSrcB=10 ResultSrc=10; IRWrite=NextPC=MemReady.
//   DECODE: ALUSrcA=1 ALUSrcB=10 ResultSrc=10. MEMADR: ALUSrcA=0 ALUSrcB=01.
//   MEMRD : AdrSrc=1. MEMWB: ResultSrc=01 RegW=1. MEMWR: AdrSrc=1 MemW=1.
//   EXECR : ALUSrcB=00 ALUOp=1. EXECI: ALUSrcB=01 ALUOp=1.
//   ALUWB : ResultSrc=00, RegW=~NoWr. BRANCH: ALUSrcB=01 ResultSrc=10 PCS=1.
//  NoWr flop: loaded in DECODE with 1 when Funct[4:1] is 1010 (CMP) or 1000 (TST), else 0.
//  Transitions:
//   FETCH : ->DECODE if MemReady, else hold.
//   DECODE: Op=01 ->MEMADR; Op=00 ->EXECI if Funct[5], else EXECR; Op=10 ->BRANCH;
//           Op=11 ->FETCH with Illegal=1 for that cycle.
//   MEMADR: Funct[0] ->MEMRD, else ->MEMWR.
//   MEMRD : MemReady ->MEMWB, else hold.
//   MEMWR : MemReady ->FETCH, else hold; MemW stays 1 while holding.
//   EXECR, EXECI ->ALUWB. MEMWB, ALUWB, BRANCH ->FETCH.
//   Illegal encodings (10..15) ->FETCH on the next edge; all enables 0 while there.
//  Latency with MemReady=1: B=3, DP=4, STR=4, LDR=5 cycles.
//  Each wait cycle adds 1 cycle in FETCH/MEMRD/MEMWR.
//  Reset: nRESET low asynchronously forces State=FETCH, NoWr=0, Illegal=0.
//   While low, IRWrite, NextPC, RegW, MemW, PCS are all forced 0.
//   Reset mid-instruction abandons it; no partial writeback.
//   The first FETCH starts on the first CLK edge after nRESET rises.
//  PCS: MEMWB/ALUWB with Rd=15 assert PCS together with RegW. For CMP/TST, RegW=0, so PCS=0.
// TESTING
//  ADD R1,R2,R3 (Op=00,Funct=001000), MemReady=1
//   -> states 0,1,6,8,0; RegW=1 only in ALUWB; ALUOp=1 in EXECR.
//  LDR (Op=01,Funct=011001), MemReady low 2 cycles in MEMRD
//   -> 0,1,2,3,3,3,4,0; ResultSrc=01 and RegW=1 in MEMWB.
//  STR (Funct[0]=0) -> 0,1,2,5,0 with MemW=1 only in MEMWR; RegW never asserted.
//  CMP (Funct=010101) -> ALUWB with RegW=0, PCS=0.
//   ADD with Rd=15 -> RegW=PCS=1 in ALUWB.
//  B (Op=10) -> 0,1,9,0 with PCS=1 in BRANCH.
//   Op=11 -> DECODE->FETCH with a 1-cycle Illegal pulse.
//  Drop nRESET while in MEMWR -> State=0 immediately with MemW=0; restart via FETCH after release.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM core: fetch, decode, address/execute, writeback.
// RegW/MemW/PCS leave here unconditioned; downstream conditional logic gates them with CondEx.
module multicycle_main_fsm #(
  parameter int STATE_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               PCS,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state_q, state_d;
  logic   nowr_q, nowr_d;
  logic   mem_rdy;
  logic   irw, regw, memw, pcs, ill;

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= FETCH;
      nowr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nowr_q  <= nowr_d;
    end
  end

  // CMP and TST only set flags, so their ALU writeback must not touch the register file.
  assign nowr_d = (state_q == DECODE) ? (Funct[4:1] == 4'b1010 || Funct[4:1] == 4'b1000)
                                      : nowr_q;

  always_comb begin
    state_d   = FETCH;
    irw       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    pcs       = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_rdy;
        state_d   = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: begin
            state_d = FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = mem_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
        pcs       = (Rd == 4'd15);
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        memw    = 1'b1;
        state_d = mem_rdy ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        regw = ~nowr_q;
        pcs  = ~nowr_q & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcs       = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are held off while reset is asserted even though the state already reads FETCH.
  assign IRWrite = irw  & nRESET;
  assign NextPC  = irw  & nRESET;
  assign RegW    = regw & nRESET;
  assign MemW    = memw & nRESET;
  assign PCS     = pcs  & nRESET;
  assign Illegal = ill  & nRESET;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class cycle by cycle
// against hand-written state and enable sequences.
module tb_multicycle_main_fsm;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'd0;
  logic       MemReady = 1'b0;
  logic       IRWrite, NextPC, RegW, MemW, PCS, AdrSrc, ALUSrcA, ALUOp, Illegal;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;
  logic [4:0] ctl;

  int total = 0;
  int bad   = 0;

  multicycle_main_fsm #(.STATE_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .nRESET(nRESET), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  // {IRWrite, RegW, MemW, PCS, Illegal}
  assign ctl = {IRWrite, RegW, MemW, PCS, Illegal};

  task automatic test_reset();
    #1 nRESET = 1'b0;
    MemReady = 1'b1;
    #6;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", State); end
    total++; if ({IRWrite, NextPC, RegW, MemW, PCS} !== 5'b0) begin
      bad++; $display("FAIL reset_enables got=%b want=00000", {IRWrite, NextPC, RegW, MemW, PCS});
    end
    @(negedge CLK);
    nRESET = 1'b1;
    MemReady = 1'b0;
    #1;
    total++; if (IRWrite !== 1'b0 || NextPC !== 1'b0) begin
      bad++; $display("FAIL fetch_wait_en got=%b%b want=00", IRWrite, NextPC);
    end
    @(negedge CLK);
    total++; if (State !== 4'd0) begin bad++; $display("FAIL fetch_hold got=%0d want=0", State); end
    MemReady = 1'b1;
    #1;
    total++; if (IRWrite !== 1'b1 || NextPC !== 1'b1) begin
      bad++; $display("FAIL fetch_ready_en got=%b%b want=11", IRWrite, NextPC);
    end
  endtask

  task automatic test_add_reg();
    int         es[5] = '{0, 1, 6, 8, 0};
    logic [4:0] ec[5] = '{5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b10000};
    logic       eo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL add_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL add_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      total++; if (ALUOp !== eo[i]) begin bad++; $display("FAIL add_aluop c%0d got=%b want=%b", i, ALUOp, eo[i]); end
      if (i == 0) begin
        total++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin
          bad++; $display("FAIL add_fetch_mux got=%b want=11010", {ALUSrcA, ALUSrcB, ResultSrc});
        end
      end
      if (i == 2) begin
        total++; if (ALUSrcB !== 2'b00) begin bad++; $display("FAIL add_execr_srcb got=%b want=00", ALUSrcB); end
      end
      if (i < 4) @(negedge CLK);
    end
  endtask

  task automatic test_ldr_wait();
    int         es[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic       mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] ec[8] = '{5'b10000, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b01000, 5'b10000};
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    for (int i = 0; i < 8; i++) begin
      MemReady = mr[i];
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL ldr_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL ldr_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      if (i == 3) begin
        total++; if (AdrSrc !== 1'b1) begin bad++; $display("FAIL ldr_adrsrc got=%b want=1", AdrSrc); end
      end
      if (i == 6) begin
        total++; if (ResultSrc !== 2'b01) begin bad++; $display("FAIL ldr_resultsrc got=%b want=01", ResultSrc); end
      end
      if (i < 7) @(negedge CLK);
    end
  endtask

  task automatic test_str_wait();
    int         es[6] = '{0, 1, 2, 5, 5, 0};
    logic       mr[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] ec[6] = '{5'b10000, 5'b0, 5'b0, 5'b00100, 5'b00100, 5'b10000};
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd4;
    for (int i = 0; i < 6; i++) begin
      MemReady = mr[i];
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL str_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL str_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      if (i < 5) @(negedge CLK);
    end
  endtask

  task automatic test_cmp_tst();
    int         es[5] = '{0, 1, 6, 8, 0};
    logic [4:0] ec[5] = '{5'b10000, 5'b0, 5'b0, 5'b0, 5'b10000};
    logic [5:0] fn[2] = '{6'b010101, 6'b010001};
    MemReady = 1'b1; Op = 2'b00; Rd = 4'd15;
    for (int k = 0; k < 2; k++) begin
      Funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL cmp%0d_state c%0d got=%0d want=%0d", k, i, State, es[i]); end
        total++; if (ctl !== ec[i]) begin bad++; $display("FAIL cmp%0d_ctl c%0d got=%b want=%b", k, i, ctl, ec[i]); end
        if (i < 4) @(negedge CLK);
      end
      @(negedge CLK);
      // the bench just left FETCH; walk the pipeline back to FETCH via an Op=11 decode
      Op = 2'b11;
      @(negedge CLK);
      Op = 2'b00;
    end
  endtask

  task automatic test_add_pc();
    int         es[5] = '{0, 1, 7, 8, 0};
    logic [4:0] ec[5] = '{5'b10000, 5'b0, 5'b0, 5'b01010, 5'b10000};
    Op = 2'b00; Funct = 6'b101000; Rd = 4'd15; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL addpc_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL addpc_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      if (i < 4) @(negedge CLK);
    end
  endtask

  task automatic test_branch();
    int         es[4] = '{0, 1, 9, 0};
    logic [4:0] ec[4] = '{5'b10000, 5'b0, 5'b00010, 5'b10000};
    Op = 2'b10; Funct = 6'b100000; Rd = 4'd0; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL b_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL b_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      if (i < 3) @(negedge CLK);
    end
  endtask

  task automatic test_illegal();
    int         es[3] = '{0, 1, 0};
    logic [4:0] ec[3] = '{5'b10000, 5'b00001, 5'b10000};
    Op = 2'b11; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL ill_state c%0d got=%0d want=%0d", i, State, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL ill_ctl c%0d got=%b want=%b", i, ctl, ec[i]); end
      if (i < 2) @(negedge CLK);
    end
  endtask

  task automatic test_reset_in_memwr();
    int es[4] = '{0, 1, 2, 5};
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd5; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b0;
      #1;
      total++; if (State !== es[i][3:0]) begin bad++; $display("FAIL rstwr_state c%0d got=%0d want=%0d", i, State, es[i]); end
      if (i < 3) @(negedge CLK);
    end
    total++; if (MemW !== 1'b1) begin bad++; $display("FAIL rstwr_memw_before got=%b want=1", MemW); end
    MemReady = 1'b1;
    nRESET = 1'b0;
    #1;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL rstwr_state_async got=%0d want=0", State); end
    total++; if ({IRWrite, RegW, MemW, PCS} !== 4'b0) begin
      bad++; $display("FAIL rstwr_enables got=%b want=0000", {IRWrite, RegW, MemW, PCS});
    end
    @(negedge CLK);
    nRESET = 1'b1;
    #1;
    total++; if (State !== 4'd0 || IRWrite !== 1'b1) begin
      bad++; $display("FAIL rstwr_release got=%0d/%b want=0/1", State, IRWrite);
    end
    @(negedge CLK);
    #1;
    total++; if (State !== 4'd1) begin bad++; $display("FAIL rstwr_restart got=%0d want=1", State); end
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_ldr_wait();
    test_str_wait();
    test_cmp_tst();
    test_add_pc();
    test_branch();
    test_illegal();
    test_reset_in_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
